// File: rtl/mouse_accum.sv
// Accumulates HPS PS/2 mouse packets into saturating signed X/Y deltas and serves Sega-mouse snapshots on TAKE; optional idle flush via MOUSE_IDLE_TIMEOUT_EN.
// Latency: a packet is absorbed at the first edge after its toggle changes; TAKE in cycle n gives MOUSE_OUT valid in cycle n+1.
// Backpressure: none; packets are never dropped, and TAKE arriving during the one-cycle snapshot state is ignored.
module mouse_accum #(
    parameter int ACC_W     = 10,
    parameter int TIMEOUT_W = 20
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CE,
    input  logic [24:0] PS2_MOUSE,
    input  logic [2:0]  OPT,
    input  logic        TAKE,
    output logic [24:0] MOUSE_OUT,
    output logic        PENDING
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_SNAP = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] ext9(input logic [8:0] v);
        return {{(ACC_W-9){v[8]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    // Returns {ovf, sign, magnitude[7:0]}; -256 fits the 9-bit Sega range, +256 does not.
    function automatic logic [9:0] encode_axis(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        logic             ovf;
        mag = a[ACC_W-1] ? ACC_W'(-a) : ACC_W'(a);
        ovf = a[ACC_W-1] ? (mag > ACC_W'(256)) : (mag > ACC_W'(255));
        return {ovf, a[ACC_W-1], ovf ? 8'hFF : mag[7:0]};
    endfunction

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_y_q, acc_x_d, acc_y_d;
    logic signed [ACC_W-1:0] dx, dy, dy_raw, base_x, base_y;
    logic [2:0]              btn_q, btn_d, btn_pkt;
    logic                    chg_q, chg_d, pend_d;
    logic                    tog_q, armed_q;
    logic                    pkt, take_fire, tmo, clr;
    logic [24:0]             out_q;
    logic [9:0]              enc_x, enc_y;
    logic [2:0]              unused_ps2;

    assign unused_ps2 = {PS2_MOUSE[7:6], PS2_MOUSE[3]};

`ifdef MOUSE_IDLE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_q;

    // Wraps to zero on terminal count, which doubles as the restart.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            tmo_cnt_q <= '0;
        else if (TAKE)
            tmo_cnt_q <= '0;
        else if (CE)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    assign tmo = CE && !TAKE && (&tmo_cnt_q);
`else
    localparam int unused_timeout_w = TIMEOUT_W;
    logic unused_ce;
    assign unused_ce = CE;
    assign tmo       = 1'b0;
`endif

    always_comb begin
        // armed_q masks the first edge after reset so a held-high toggle is not seen as a packet
        pkt       = armed_q && (PS2_MOUSE[24] != tog_q);
        take_fire = TAKE && (state_q != S_SNAP);
        clr       = take_fire || tmo;

        dx     = ext9({PS2_MOUSE[4], PS2_MOUSE[15:8]});
        dy_raw = ext9({PS2_MOUSE[5], PS2_MOUSE[23:16]});
        dy     = OPT[0] ? -dy_raw : dy_raw;
        if (OPT[2]) begin
            dx = dx >>> 1;
            dy = dy >>> 1;
        end
        btn_pkt = OPT[1] ? {PS2_MOUSE[2], PS2_MOUSE[0], PS2_MOUSE[1]} : PS2_MOUSE[2:0];

        // A packet landing with a clear starts the fresh accumulation rather than being lost
        base_x  = clr ? '0 : acc_x_q;
        base_y  = clr ? '0 : acc_y_q;
        acc_x_d = pkt ? sat_add(base_x, dx) : base_x;
        acc_y_d = pkt ? sat_add(base_y, dy) : base_y;
        btn_d   = pkt ? btn_pkt : btn_q;
        chg_d   = (!clr && chg_q) || (pkt && (btn_pkt != btn_q));
        pend_d  = (acc_x_d != '0) || (acc_y_d != '0) || chg_d;

        state_d = state_q;
        if (take_fire)
            state_d = S_SNAP;
        else if (tmo)
            state_d = pend_d ? S_ACC : S_IDLE;
        else begin
            case (state_q)
                S_ACC:   state_d = S_ACC;
                default: state_d = pend_d ? S_ACC : S_IDLE;
            endcase
        end

        enc_x = encode_axis(acc_x_q);
        enc_y = encode_axis(acc_y_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            acc_x_q <= '0;
            acc_y_q <= '0;
            btn_q   <= '0;
            chg_q   <= 1'b0;
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            out_q   <= '0;
        end else begin
            tog_q   <= PS2_MOUSE[24];
            armed_q <= 1'b1;
            state_q <= state_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            btn_q   <= btn_d;
            chg_q   <= chg_d;
            if (take_fire)
                out_q <= {~out_q[24], enc_y[7:0], enc_x[7:0], enc_y[9], enc_x[9],
                          enc_y[8], enc_x[8], 1'b0, btn_q};
        end
    end

    assign MOUSE_OUT = out_q;
    assign PENDING   = (state_q == S_ACC);

endmodule

// File: tb/tb_mouse_accum.sv
// Bench for mouse_accum: directed tables and sequences plus random traffic against a cycle-level reference model.
module tb_mouse_accum;

`ifdef MOUSE_IDLE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 20;
`endif
    localparam int AMAX = 511;
    localparam int AMIN = -512;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        CE = 1'b1;
    logic [24:0] PS2_MOUSE = '0;
    logic [2:0]  OPT = '0;
    logic        TAKE = 1'b0;
    logic [24:0] MOUSE_OUT;
    logic        PENDING;

    mouse_accum #(.ACC_W(10), .TIMEOUT_W(TW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CE(CE), .PS2_MOUSE(PS2_MOUSE),
        .OPT(OPT), .TAKE(TAKE), .MOUSE_OUT(MOUSE_OUT), .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    // stimulus bookkeeping
    logic       tog = 1'b0;
    bit         in_pkt = 1'b0;
    int         in_dx, in_dy;
    logic [2:0] in_btn;

    // reference model state
    int          mx, my;
    logic [2:0]  mbtn;
    bit          mchg, mpend, msnap;
    logic [24:0] mout;

    typedef struct {
        int         dx;
        int         dy;
        logic [2:0] btn;
        logic [2:0] opt;
        int         reps;
        logic [7:0] xm;
        logic [7:0] ym;
        logic       xs, ys, xo, yo;
        logic [2:0] bo;
    } vec_t;
    vec_t tbl [10];

    int         rdx, rdy;
    logic [2:0] rbtn = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int msat(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    // {ovf, sign, field} of a Sega axis report for signed motion v
    function automatic logic [9:0] menc(input int v);
        int m;
        bit neg, o;
        neg = (v < 0);
        m   = neg ? -v : v;
        o   = neg ? (m > 256) : (m > 255);
        return {o, neg, o ? 8'hFF : 8'(m % 256)};
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mbtn = '0; mchg = 0; mpend = 0; msnap = 0; mout = '0;
    endtask

    task automatic model_step();
        bit tf;
        int d_x, d_y;
        logic [2:0] nb;
        logic [9:0] ex, ey;
        tf = TAKE && !msnap;
        if (tf) begin
            ex = menc(mx);
            ey = menc(my);
            mout = {~mout[24], ey[7:0], ex[7:0], ey[9], ex[9], ey[8], ex[8], 1'b0, mbtn};
            mx = 0; my = 0; mchg = 0;
        end
        if (in_pkt) begin
            d_x = in_dx;
            d_y = OPT[0] ? -in_dy : in_dy;
            if (OPT[2]) begin
                d_x = d_x >>> 1;
                d_y = d_y >>> 1;
            end
            mx = msat(mx + d_x);
            my = msat(my + d_y);
            nb = OPT[1] ? {in_btn[2], in_btn[0], in_btn[1]} : in_btn;
            if (nb != mbtn) mchg = 1;
            mbtn = nb;
        end
        mpend = !tf && (mpend || mx != 0 || my != 0 || mchg);
        msnap = tf;
    endtask

    task automatic set_pkt(input int dx, input int dy, input logic [2:0] btn);
        logic [8:0] x9, y9;
        x9 = 9'(dx);
        y9 = 9'(dy);
        tog = ~tog;
        PS2_MOUSE = {tog, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, btn};
        in_pkt = 1; in_dx = dx; in_dy = dy; in_btn = btn;
    endtask

    task automatic cyc_raw();
        @(posedge CLK);
        #1;
        in_pkt = 0;
        TAKE = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        check("mouse_out", MOUSE_OUT, mout);
        check("pending", {31'd0, PENDING}, {31'd0, mpend});
        in_pkt = 0;
        TAKE = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        TAKE = 1'b0;
        in_pkt = 0;
        model_reset();
        #1;
        check("rst_mouse_out", MOUSE_OUT, 25'd0);
        check("rst_pending", {31'd0, PENDING}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{10,   0,   3'b000, 3'b000, 3,  8'd30,  8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[1] = '{100,  0,   3'b000, 3'b000, 40, 8'hFF,  8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        tbl[2] = '{-100, 0,   3'b000, 3'b000, 40, 8'hFF,  8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        tbl[3] = '{0,    4,   3'b001, 3'b011, 1,  8'd0,   8'd4,  1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
        tbl[4] = '{-128, 0,   3'b000, 3'b000, 2,  8'd0,   8'd0,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[5] = '{128,  0,   3'b000, 3'b000, 2,  8'hFF,  8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        tbl[6] = '{255,  0,   3'b000, 3'b000, 1,  8'hFF,  8'd0,  1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[7] = '{-7,   -9,  3'b100, 3'b100, 2,  8'd8,   8'd10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[8] = '{0,    -3,  3'b011, 3'b001, 3,  8'd0,   8'd9,  1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
        tbl[9] = '{-256, -256, 3'b110, 3'b101, 1, 8'h80,  8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110};

        #2;
        do_reset();

`ifdef MOUSE_IDLE_TIMEOUT_EN
        // stale motion is flushed after a full counter wrap without TAKE
        set_pkt(9, 0, 3'b000);
        cyc_raw();
        repeat (18) cyc_raw();
        check("t6_pending", {31'd0, PENDING}, 32'd0);
        TAKE = 1'b1;
        cyc_raw();
        check("t6_xmag", {24'd0, MOUSE_OUT[15:8]}, 32'd0);
        check("t6_toggle", {31'd0, MOUSE_OUT[24]}, 32'd1);
`else
        // three packets summed into one report
        set_pkt(10, 0, 3'b000); cyc();
        set_pkt(20, 0, 3'b000); cyc();
        set_pkt(-5, 0, 3'b000); cyc();
        check("t1_pend_before", {31'd0, PENDING}, 32'd1);
        TAKE = 1'b1;
        cyc();
        check("t1_xmag", {24'd0, MOUSE_OUT[15:8]}, 32'd25);
        check("t1_xsign", {31'd0, MOUSE_OUT[4]}, 32'd0);
        check("t1_xovf", {31'd0, MOUSE_OUT[6]}, 32'd0);
        check("t1_toggle", {31'd0, MOUSE_OUT[24]}, 32'd1);
        check("t1_pend_after", {31'd0, PENDING}, 32'd0);
        cyc();

        // packet coinciding with TAKE goes to the following report
        set_pkt(0, 7, 3'b000); cyc();
        set_pkt(0, 3, 3'b000); TAKE = 1'b1; cyc();
        check("t3_first_ymag", {24'd0, MOUSE_OUT[23:16]}, 32'd7);
        cyc();
        check("t3_pend_held", {31'd0, PENDING}, 32'd1);
        TAKE = 1'b1; cyc();
        check("t3_second_ymag", {24'd0, MOUSE_OUT[23:16]}, 32'd3);
        cyc();

        for (int i = 0; i < 10; i++) begin
            OPT = tbl[i].opt;
            for (int r = 0; r < tbl[i].reps; r++) begin
                set_pkt(tbl[i].dx, tbl[i].dy, tbl[i].btn);
                cyc();
            end
            cyc();
            TAKE = 1'b1;
            cyc();
            check($sformatf("tbl%0d_xmag", i), {24'd0, MOUSE_OUT[15:8]}, {24'd0, tbl[i].xm});
            check($sformatf("tbl%0d_ymag", i), {24'd0, MOUSE_OUT[23:16]}, {24'd0, tbl[i].ym});
            check($sformatf("tbl%0d_flags", i), {28'd0, MOUSE_OUT[7:4]},
                  {28'd0, tbl[i].yo, tbl[i].xo, tbl[i].ys, tbl[i].xs});
            check($sformatf("tbl%0d_btn", i), {28'd0, MOUSE_OUT[3:0]}, {28'd0, 1'b0, tbl[i].bo});
            cyc();
        end
        OPT = 3'b000;

        // reset mid-accumulation with the toggle held high
        if (tog == 1'b0) begin
            set_pkt(50, 0, 3'b000); cyc();
        end else begin
            set_pkt(20, 0, 3'b000); cyc();
            set_pkt(30, 0, 3'b000); cyc();
        end
        check("t5_pend_before", {31'd0, PENDING}, 32'd1);
        do_reset();
        repeat (3) cyc();
        check("t5_no_pkt", {31'd0, PENDING}, 32'd0);
        TAKE = 1'b1;
        cyc();
        check("t5_xmag", {24'd0, MOUSE_OUT[15:8]}, 32'd0);
        check("t5_toggle", {31'd0, MOUSE_OUT[24]}, 32'd1);
        cyc();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) OPT = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0) begin
                    rdx = int'($urandom_range(0, 511)) - 256;
                    rdy = int'($urandom_range(0, 511)) - 256;
                end else begin
                    rdx = int'($urandom_range(0, 40)) - 20;
                    rdy = int'($urandom_range(0, 40)) - 20;
                end
                if ($urandom_range(0, 7) == 0) rbtn = 3'($urandom_range(0, 7));
                set_pkt(rdx, rdy, rbtn);
            end else begin
                PS2_MOUSE[23:0] = 24'($urandom);
            end
            TAKE = ($urandom_range(0, 5) == 0);
            cyc();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
